// File: rtl/dll_seq_pkg.sv
// Shared constants for the DLL lock sequencer and its helpers.
//   - FSM state encoding (binary, 3 bits; unused codes recover to ST_RESET_DLL)
//   - attempt counter width
//   - minimum DLL reset pulse length in CLKIN cycles
package dll_seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_RESET_DLL = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] ST_STABILIZE = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUNNING   = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAILED    = 3'd4;

  localparam int ATTEMPT_W = 4;

  // The DLL primitive needs its RST held for at least this many CLKIN cycles.
  localparam int DLL_MIN_RST_PULSE = 3;

endpackage

// File: rtl/dll_seq_sync2.sv
// Two-flop synchronizer for asynchronous DLL status inputs.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops to 0
//   d     - asynchronous input
//   q     - synchronized output, 2 clock edges of latency
module dll_seq_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dll_lock_sequencer.sv
// DLL lock sequencer: pulses the DLL reset, waits for LOCKED with a timeout
// and bounded retries, debounces lock, then releases an active-low system
// reset to logic clocked by the DLL outputs. Runs on the free-running
// reference clock (the DLL's CLKIN) because DLL output clocks are invalid
// before lock.
// Ports:
//   clkin        - reference clock, single clock domain
//   rst_n        - asynchronous active-low reset
//   locked       - DLL LOCKED, asynchronous, synchronized internally
//   force_relock - 1-cycle synchronous request to restart the sequence
//   dll_rst      - DLL RST, active high
//   sys_rst_n    - active-low system reset, high only in RUNNING
//   lock_ok      - high in RUNNING
//   fail         - high in FAILED
//   attempt_cnt  - failed attempts since last RUNNING entry / force_relock
//   state_dbg    - current FSM state (dll_seq_pkg encoding)
module dll_lock_sequencer
  import dll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 3,
  parameter int LOCK_TIMEOUT     = 20000,
  parameter int STABLE_CYCLES    = 16,
  parameter int MAX_ATTEMPTS     = 4,
  parameter int CNT_W            = 16
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 locked,
  input  logic                 force_relock,
  output logic                 dll_rst,
  output logic                 sys_rst_n,
  output logic                 lock_ok,
  output logic                 fail,
  output logic [ATTEMPT_W-1:0] attempt_cnt,
  output logic [STATE_W-1:0]   state_dbg
);

  // Terminal compare values for the shared counter.
  localparam logic [CNT_W-1:0]     RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE      = CNT_W'(1);
  localparam logic [ATTEMPT_W-1:0] ATT_MAX      = ATTEMPT_W'(MAX_ATTEMPTS);
  localparam logic [ATTEMPT_W-1:0] ATT_ONE      = ATTEMPT_W'(1);

  logic                 locked_s;
  logic [STATE_W-1:0]   state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [ATTEMPT_W-1:0] att_nx;
  logic                 attempt_fail;

  dll_seq_sync2 u_sync_locked (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  assign state_dbg = state;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    att_nx       = attempt_cnt;
    attempt_fail = 1'b0;

    if (force_relock) begin
      // Restart wins over every other event on the same edge.
      state_nx = ST_RESET_DLL;
      cnt_nx   = '0;
      att_nx   = '0;
    end else begin
      case (state)
        ST_RESET_DLL: begin
          if (cnt == RST_LAST) begin
            state_nx = ST_WAIT_LOCK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_nx = ST_STABILIZE;
            cnt_nx   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            attempt_fail = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        ST_STABILIZE: begin
          if (!locked_s) begin
            attempt_fail = 1'b1;
          end else if (cnt == STABLE_LAST) begin
            state_nx = ST_RUNNING;
            cnt_nx   = '0;
            att_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        ST_RUNNING: begin
          if (!locked_s) begin
            state_nx = ST_RESET_DLL;
            cnt_nx   = '0;
          end
        end
        ST_FAILED: begin
          cnt_nx = '0;
        end
        default: begin
          state_nx = ST_RESET_DLL;
          cnt_nx   = '0;
        end
      endcase

      if (attempt_fail) begin
        att_nx   = attempt_cnt + ATT_ONE;
        cnt_nx   = '0;
        state_nx = (att_nx == ATT_MAX) ? ST_FAILED : ST_RESET_DLL;
      end
    end
  end

  // Outputs are decoded from the next state so they move on the same edge
  // as the state register.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RESET_DLL;
      cnt         <= '0;
      attempt_cnt <= '0;
      dll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      lock_ok     <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      attempt_cnt <= att_nx;
      dll_rst     <= (state_nx == ST_RESET_DLL) || (state_nx == ST_FAILED);
      sys_rst_n   <= (state_nx == ST_RUNNING);
      lock_ok     <= (state_nx == ST_RUNNING);
      fail        <= (state_nx == ST_FAILED);
    end
  end

endmodule

// File: doc/dll_lock_sequencer.md
Name: dll_lock_sequencer

Overview:
Control stage directly downstream of the clock DLL primitive. It consumes the DLL's LOCKED output and drives the DLL's active-high RST input. It generates the power-up DLL reset pulse, waits for lock with a timeout and bounded retries, and debounces lock. It then releases a clean active-low system reset (SYS_RST_N) to logic clocked by the DLL outputs. Clocked by the free-running reference oscillator, the same clock that feeds the DLL's CLKIN, because the DLL output clocks are invalid before lock.

Parameters:
RST_PULSE_CYCLES, 3, CLKIN cycles DLL_RST is held high per attempt (min 3 per DLL requirement, max 2^CNT_W).
LOCK_TIMEOUT, 20000, CLKIN cycles allowed in WAIT_LOCK before an attempt is declared failed (≥1).
STABLE_CYCLES, 16, consecutive synchronized-LOCKED-high cycles required before release (≥1).
MAX_ATTEMPTS, 4, failed attempts allowed before FAILED (1..15).
CNT_W, 16, shared cycle-counter width; must hold max(RST_PULSE_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1.

Ports:
CLKIN  input  1  reference clock; single clock domain for the block.
RST_N  input  1  asynchronous active-low reset.
LOCKED  input  1  DLL LOCKED; asynchronous to CLKIN, passed through a 2-flop synchronizer (locked_s).
FORCE_RELOCK  input  1  synchronous 1-cycle request to restart the sequence.
DLL_RST  output  1  to DLL RST, active high.
SYS_RST_N  output  1  active-low system reset; high only in RUNNING.
LOCK_OK  output  1  high in RUNNING.
FAIL  output  1  high in FAILED.
ATTEMPT_CNT  output  4  failed attempts since the last RUNNING entry or FORCE_RELOCK.

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-low (CLKIN, RST_N).
- Reset values while RST_N=0:
  - state=RESET_DLL, cnt=0, ATTEMPT_CNT=0, sync flops=0.
  - DLL_RST=1, SYS_RST_N=0, LOCK_OK=0, FAIL=0.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state change.
- Synchronizer latency: 2 edges. The FSM sees locked_s.
- RESET_DLL:
  - DLL_RST=1.
  - cnt increments each edge; at cnt==RST_PULSE_CYCLES-1 → WAIT_LOCK with cnt=0.
  - DLL_RST is high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - DLL_RST=0.
  - locked_s=1 → STABILIZE with cnt=0.
  - Else at cnt==LOCK_TIMEOUT-1 → attempt fail. Otherwise cnt++.
- STABILIZE:
  - locked_s=0 → attempt fail.
  - Else at cnt==STABLE_CYCLES-1 → RUNNING. Otherwise cnt++.
- Attempt fail: ATTEMPT_CNT++. If the new value == MAX_ATTEMPTS → FAILED, else → RESET_DLL with cnt=0.
- RUNNING:
  - SYS_RST_N=1, LOCK_OK=1, ATTEMPT_CNT cleared on entry.
  - locked_s=0 → RESET_DLL with cnt=0. SYS_RST_N drops on that edge, i.e. 3 edges after LOCKED falls.
- FAILED:
  - DLL_RST=1 (DLL held in reset), SYS_RST_N=0, FAIL=1, ATTEMPT_CNT held.
  - Exits only via RST_N or FORCE_RELOCK.
- FORCE_RELOCK=1 in any state → RESET_DLL, cnt=0, ATTEMPT_CNT=0, FAIL=0, SYS_RST_N=0 on that edge.
  - Highest priority, above timeout, lock loss and stabilize completion on the same edge.
- Release latency: LOCKED rising in WAIT_LOCK and held → SYS_RST_N rises on edge 3+STABLE_CYCLES after LOCKED rises.
- LOCKED glitches shorter than 1 CLKIN period may be missed. This is acceptable; no glitch filter beyond STABILIZE.
- Counter never wraps: every state exits or saturates at its terminal compare.
- ATTEMPT_CNT width is fixed at 4 bits.
- RST_N assertion mid-sequence returns to reset values immediately (asynchronous), including DLL_RST=1.
- State encoding (binary, 3 bits): RESET_DLL=0, WAIT_LOCK=1, STABILIZE=2, RUNNING=3, FAILED=4. Unused codes → RESET_DLL.

Decomposition:
- Shared package/include dll_seq_pkg: state encoding constants, ATTEMPT_CNT width (4), DLL minimum reset-pulse constant (3).
- One sub-module: dll_seq_sync2, the 2-flop synchronizer with async active-low reset clearing to 0. Reused for other DLL status inputs.
- FSM, counter and output registers stay in dll_lock_sequencer.

Test Plan:
- Power-up lock, defaults: release RST_N; LOCKED rises 50 cycles later and holds → DLL_RST high exactly 3 cycles, SYS_RST_N rises 19 edges after LOCKED, LOCK_OK=1, ATTEMPT_CNT=0.
- Timeout/FAILED (LOCK_TIMEOUT=100, MAX_ATTEMPTS=2, LOCKED=0): DLL_RST pulses 3 cycles, low 100, pulses 3, low 100 → FAILED; FAIL=1, DLL_RST=1, ATTEMPT_CNT=2.
- Lock loss in RUNNING: LOCKED falls → SYS_RST_N=0 and DLL_RST=1 on 3rd edge. LOCKED returns and holds → re-release; ATTEMPT_CNT=0.
- Chatter in STABILIZE (STABLE_CYCLES=16): LOCKED high 10 cycles then low 1 → ATTEMPT_CNT=1, new 3-cycle DLL_RST pulse, SYS_RST_N stays 0.
- FORCE_RELOCK from FAILED and from RUNNING on the same edge as LOCKED drop → RESET_DLL, FAIL=0, ATTEMPT_CNT=0, DLL_RST pulse of exactly 3 cycles.
- RST_N asserted mid-WAIT_LOCK (cnt=57) → DLL_RST=1 and SYS_RST_N=0 with no clock edge. After release, the sequence restarts from a full 3-cycle pulse.
